// File: rtl/rv32_pkg.sv
// Shared RV32I encodings and small helpers for the memory/writeback stages.
package rv32_pkg;

  // Result-select encodings; 2'b11 is treated as ALU.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Load/store funct3 size and sign encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory-access handshake state.
  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic        load;
    logic        store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } ex_mem_t;

  // Halfwords need bit 0 clear, words need both low bits clear; bytes never fault.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
    is_misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                    ((funct3 == F3_W) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_wb_cycle_if.sv
// Data-memory request bus: valid/ready request with same-cycle read data.
interface mem_wb_cycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_wb_cycle_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane and extends it.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_lane = rdata_i[{addr_i[1], 4'b0000} +: 16];

  // Extend the selected lane according to size and signedness.
  always_comb begin
    // NOTE: every branch of a combinational block must assign its outputs, so a default comes first to avoid a latch.
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   data_o = {24'd0, byte_lane};
      F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   data_o = {16'd0, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_cycle.sv
// RV32I memory and writeback stages: EX/MEM register, data-memory handshake,
// load alignment and the MEM/WB register feeding the register file.
module mem_wb_cycle
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             LoadE,
  input  logic             StoreE,
  input  logic [2:0]       Funct3E,
  input  logic [4:0]       RD_E,
  input  logic [XLEN-1:0]  ALUResultE,
  input  logic [XLEN-1:0]  WriteDataE,
  input  logic [XLEN-1:0]  PCPlus4E,
  mem_wb_cycle_if.master   mem,
  output logic             StallM,
  output logic             MisalignM,
  output logic             RegWriteW,
  output logic [4:0]       RDW,
  output logic [XLEN-1:0]  ResultW
);

  ex_mem_t     m_q, m_d;
  mem_state_e  state_q, state_d;
  logic        reg_write_w_q, reg_write_w_d;
  logic [4:0]  rd_w_q, rd_w_d;
  logic [31:0] result_w_q, result_w_d;
  logic        access;
  logic        misaligned;
  logic [31:0] load_data;

  assign access     = m_q.load | m_q.store;
  assign misaligned = access & is_misaligned(m_q.funct3, m_q.alu_result[1:0]);
  assign MisalignM  = misaligned;

  // Memory request driven straight from the M register so it stays stable while waiting.
  assign mem.mem_req  = access & ~misaligned & (state_q == RUN || state_q == WAIT);
  assign mem.mem_we   = m_q.store;
  assign mem.mem_addr = {m_q.alu_result[31:2], 2'b00};

  // Store lane replication and byte strobes; strobes stay zero for loads.
  always_comb begin
    mem.mem_wdata = m_q.write_data;
    mem.mem_wstrb = 4'b0000;
    case (m_q.funct3)
      F3_B: begin
        mem.mem_wdata = {4{m_q.write_data[7:0]}};
        mem.mem_wstrb = 4'b0001 << m_q.alu_result[1:0];
      end
      F3_H: begin
        mem.mem_wdata = {2{m_q.write_data[15:0]}};
        mem.mem_wstrb = 4'b0011 << {m_q.alu_result[1], 1'b0};
      end
      default: begin
        mem.mem_wdata = m_q.write_data;
        mem.mem_wstrb = 4'b1111;
      end
    endcase
    if (!m_q.store) mem.mem_wstrb = 4'b0000;
  end

  // Handshake FSM next state and the upstream stall.
  always_comb begin
    state_d = state_q;
    StallM  = 1'b0;
    case (state_q)
      RUN: begin
        StallM = mem.mem_req & ~mem.mem_ready;
        if (mem.mem_req && !mem.mem_ready) state_d = WAIT;
      end
      WAIT: begin
        StallM = ~mem.mem_ready;
        if (mem.mem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Handshake FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // EX/MEM register next value: capture E inputs unless the stage is stalled.
  always_comb begin
    m_d = m_q;
    if (!StallM) begin
      m_d.reg_write  = RegWriteE;
      m_d.result_src = ResultSrcE;
      m_d.load       = LoadE;
      m_d.store      = StoreE;
      m_d.funct3     = Funct3E;
      m_d.rd         = RD_E;
      m_d.alu_result = ALUResultE;
      m_d.write_data = WriteDataE;
      m_d.pc_plus4   = PCPlus4E;
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) m_q <= '0;
    else     m_q <= m_d;
  end

  load_align u_load_align (
    .rdata_i  (mem.mem_rdata),
    .addr_i   (m_q.alu_result[1:0]),
    .funct3_i (m_q.funct3),
    .data_o   (load_data)
  );

  // MEM/WB next value: bubble while stalled, otherwise retire the M instruction.
  always_comb begin
    reg_write_w_d = 1'b0;
    rd_w_d        = 5'd0;
    result_w_d    = result_w_q;
    if (!StallM) begin
      reg_write_w_d = m_q.reg_write & ~misaligned & ~m_q.store;
      rd_w_d        = m_q.rd;
      case (m_q.result_src)
        RES_MEM: result_w_d = load_data;
        RES_PC4: result_w_d = m_q.pc_plus4;
        default: result_w_d = m_q.alu_result;
      endcase
    end
  end

  // MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w_q <= 1'b0;
      rd_w_q        <= 5'd0;
      result_w_q    <= 32'd0;
    end else begin
      reg_write_w_q <= reg_write_w_d;
      rd_w_q        <= rd_w_d;
      result_w_q    <= result_w_d;
    end
  end

  assign RegWriteW = reg_write_w_q;
  assign RDW       = rd_w_q;
  assign ResultW   = result_w_q;

endmodule

// File: doc/mem_wb_cycle.md
Name: mem_wb_cycle

Overview:
- Memory and writeback end of the RV32I pipeline. Registers execute-stage results (EX/MEM), drives the data-memory request with a valid/ready handshake and aligns load data with sign or zero extension.
- Registers the final result (MEM/WB) and produces RegWriteW / RDW / ResultW, which the decode stage consumes for register-file write and decode forwarding.
- Asserts StallM upstream while a memory access waits.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- RegWriteE  in  1  EX instruction writes rd.
- ResultSrcE  in  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 ALU.
- LoadE  in  1  EX instruction is a load.
- StoreE  in  1  EX instruction is a store.
- Funct3E  in  3  size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- RD_E  in  5  destination register.
- ALUResultE  in  32  ALU result; this is the effective address for loads and stores.
- WriteDataE  in  32  forwarded rs2 value for stores.
- PCPlus4E  in  32  PC+4 of the EX instruction.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  store data, lane-replicated.
- mem_wstrb  out  4  byte strobes; 0000 for loads.
- mem_ready  in  1  request accepted this cycle; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  load word.
- StallM  out  1  freeze PC / IF / ID / EX registers.
- MisalignM  out  1  one-cycle pulse on a misaligned access.
- RegWriteW  out  1  writeback enable.
- RDW  out  5  writeback register.
- ResultW  out  32  writeback data.

Behaviour:
Reset (rst=1, asynchronous):
- All M and W registers clear to zero.
- FSM goes to RUN.
- Every output is 0.

M register:
- Loads all E inputs on a rising edge when StallM=0.
- Holds its contents when StallM=1.

Memory access (combinational from the M register):
- mem_req = (LoadM | StoreM) & ~misaligned & (state==RUN | state==WAIT).
- mem_addr, mem_we and mem_wstrb are also driven from the M register.

Misalignment:
- H or HU with addr[0]=1 is misaligned.
- W with addr[1:0]≠00 is misaligned.
- On a misaligned access: no mem_req, MisalignM=1 for that cycle, and the instruction retires into W with RegWrite=0.

Store lanes:
- B: wdata = {4{d[7:0]}}, strobe = 0001<<addr[1:0].
- H: wdata = {2{d[15:0]}}, strobe = 0011<<{addr[1],1'b0}.
- W: wdata = d, strobe = 1111.

Load extract:
- Select the byte or halfword lane by addr[1:0].
- B and H sign-extend; BU and HU zero-extend; W passes the word through.

FSM, two states:
- RUN: if mem_req & ~mem_ready, go to WAIT. StallM = mem_req & ~mem_ready.
- WAIT: mem_req stays high with stable address, data and strobes. StallM = ~mem_ready. On mem_ready, go to RUN.
- A zero-wait memory (mem_ready=1 in the request cycle) never enters WAIT and never stalls.

W register, updated every edge:
- If StallM=1: bubble, i.e. RegWriteW←0 and RDW←0, ResultW holds.
- Else: RegWriteW ← RegWriteM & ~misaligned; RDW ← RD_M; ResultW ← mux(ResultSrcM) over ALU, aligned load data and PC+4.

Latency:
- E to M: 1 cycle.
- M to W: 1 cycle plus the number of wait cycles.

Boundary conditions:
- rd = x0: passed through unchanged; the register file ignores writes to x0.
- Reset asserted mid-WAIT: mem_req drops immediately and asynchronously, StallM=0, and the pending access is abandoned.
- mem_ready while mem_req=0: ignored.
- A store never sets RegWriteW, even if RegWriteE=1 is (illegally) presented with it.

Decomposition:
- Shared package rv32_pkg holds:
  - ResultSrc encodings: RES_ALU, RES_MEM, RES_PC4.
  - Funct3 load/store encodings: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state type {RUN, WAIT}.
- One natural sub-module, load_align: combinational; inputs rdata, addr[1:0], funct3; output 32-bit extended data. It is reusable by a future cache.

Test Plan:
1. ALU op with RegWriteE=1, RD_E=5, ALUResultE=0x1234, ResultSrcE=00 → two cycles later RegWriteW=1, RDW=5, ResultW=0x1234; mem_req stays 0.
2. SB with addr=0x103, WriteDataE=0xAABBCCDD, mem_ready=1 → mem_addr=0x100, mem_wstrb=1000, mem_wdata=0xDDDDDDDD, mem_we=1, StallM=0; the following W cycle has RegWriteW=0.
3. LB then LBU at addr 0x202 with mem_rdata=0x00800000 → ResultW=0xFFFFFF80, then 0x00000080.
4. LW at 0x40 with mem_ready low for 3 cycles → StallM=1 for exactly 3 cycles with mem_req and mem_addr stable, W shows bubbles, then ResultW=mem_rdata and RegWriteW=1 once.
5. LW at 0x42 → MisalignM=1 for 1 cycle, mem_req=0, RegWriteW=0.
6. JAL with ResultSrcE=10, PCPlus4E=0x84, rd=1 → ResultW=0x84, RDW=1. Asserting rst during the WAIT of scenario 4 → all outputs 0 in the same cycle and the FSM is in RUN after release.
